// File: rtl/riscv_pkg.sv
// Shared RV32I core package: fetch FSM state type, NOP encoding, XLEN, reset PC.
// Imported by fetch_unit and pc_next_gen. TRAP state exists only with FETCH_MISALIGN_CHECK_EN.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      TRAP  = 2'd3
`endif
   } fetch_state_t;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC generator: sequential (pc+4) or branch target (pc+ImmExt), mod 2^32.
// Ports: pc, PCSrc, ImmExt in; pc_next (raw), pc_plus4, misaligned (pc_next[1:0]!=0) out.
module pc_next_gen
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] ImmExt,
   output logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misaligned
);

   assign pc_plus4   = pc + 32'd4;
   assign pc_next    = PCSrc ? (pc + ImmExt) : pc_plus4;
   assign misaligned = |pc_next[1:0];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, fetches over imem req/ack, hands instr to decode via valid/ready.
// Ports: clk, rst_n; imem_req/addr/rdata/ack; instr, pc, pc_plus4, instr_valid/ready;
// PCSrc, ImmExt; misaligned. Macro FETCH_MISALIGN_CHECK_EN enables the sticky TRAP state.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ack,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] ImmExt,
   output logic            misaligned
);

   fetch_state_t    state;
   fetch_state_t    state_nx;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_nx_raw;
   logic [XLEN-1:0] pc_load;
   logic            mis_nx;
   logic            accept;

   pc_next_gen u_pc_next_gen (
      .pc         (pc_q),
      .PCSrc      (PCSrc),
      .ImmExt     (ImmExt),
      .pc_next    (pc_nx_raw),
      .pc_plus4   (pc_plus4),
      .misaligned (mis_nx)
   );

   assign accept = (state == HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic mis_q;
   // Offending address is kept in pc so the trap handler can see it.
   assign pc_load    = pc_nx_raw;
   assign misaligned = mis_q;
`else
   assign pc_load    = mis_nx ? {pc_nx_raw[XLEN-1:2], 2'b00} : pc_nx_raw;
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = FETCH;
         FETCH: if (imem_ack) state_nx = HOLD;
`ifdef FETCH_MISALIGN_CHECK_EN
         HOLD:  if (instr_ready) state_nx = mis_nx ? TRAP : FETCH;
         TRAP:  state_nx = TRAP;
`else
         HOLD:  if (instr_ready) state_nx = FETCH;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      imem_req    = (state == FETCH);
      instr_valid = (state == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
      end else begin
         if (state == FETCH && imem_ack) instr_q <= imem_rdata;
         if (accept) pc_q <= pc_load;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               mis_q <= 1'b0;
      else if (accept && mis_nx) mis_q <= 1'b1;
   end
`endif

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, reset/misalign sequences,
// randomized branch stream against a transaction-level PC model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        instr_ready;
   logic        PCSrc;
   logic [31:0] ImmExt;
   logic        misaligned;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] cur_pc;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PCSrc       (PCSrc),
      .ImmExt      (ImmExt),
      .misaligned  (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ack_dly;
      int          rdy_dly;
      logic        src;
      logic [31:0] imm;
      logic [31:0] exp_next;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock; inputs not taking part in an accept get random noise.
   task automatic tick();
      @(posedge clk);
      #1;
      PCSrc  = 1'($urandom);
      ImmExt = $urandom;
   endtask

   // One instruction: fetch at cur_pc, hold, accept with src/imm,
   // then the next request must appear at exp_next.
   task automatic do_fetch(input int ack_dly, input int rdy_dly,
                           input logic src, input logic [31:0] imm,
                           input logic [31:0] exp_next);
      chk("req_on", 32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, cur_pc);
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         chk("req_hold", {31'd0, imem_req} ^ (imem_addr ^ cur_pc), 32'd1);
      end
      imem_ack   = 1'b1;
      imem_rdata = mem_word(cur_pc);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("valid", 32'(instr_valid), 32'd1);
      chk("instr", instr, mem_word(cur_pc));
      chk("pc", pc, cur_pc);
      chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
      for (int i = 0; i < rdy_dly; i++) begin
         imem_ack = 1'(i & 1);
         tick();
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_req", 32'(imem_req), 32'd0);
         chk("stall_instr", instr ^ pc, mem_word(cur_pc) ^ cur_pc);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      PCSrc       = src;
      ImmExt      = imm;
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
      PCSrc       = 1'($urandom);
      ImmExt      = $urandom;
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, exp_next);
      cur_pc = exp_next;
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      PCSrc       = 1'b0;
      ImmExt      = '0;

      tbl[0] = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004};
      tbl[1] = '{0, 0, 1'b0, 32'h0000_0100, 32'h0000_0008};
      tbl[2] = '{1, 0, 1'b1, 32'h0000_00F8, 32'h0000_0100};
      tbl[3] = '{0, 1, 1'b1, 32'hFFFF_FFF0, 32'h0000_00F0};
      tbl[4] = '{2, 0, 1'b1, 32'h0000_0010, 32'h0000_0100};
      tbl[5] = '{0, 0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0104};
      tbl[6] = '{0, 2, 1'b1, 32'hFFFF_FEF8, 32'hFFFF_FFFC};
      tbl[7] = '{3, 0, 1'b0, 32'h0000_0000, 32'h0000_0000};
      tbl[8] = '{0, 5, 1'b0, 32'h0000_0008, 32'h0000_0004};

      tick();
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_mis", 32'(misaligned), 32'd0);
      rst_n = 1'b1;
      #2;
      chk("idle_req", 32'(imem_req), 32'd0);
      tick();
      cur_pc = 32'h0;

      foreach (tbl[i])
         do_fetch(tbl[i].ack_dly, tbl[i].rdy_dly, tbl[i].src,
                  tbl[i].imm, tbl[i].exp_next);

      // Reset in the middle of a fetch; memory acks 2 cycles later.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req), 32'd0);
      tick();
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack   = 1'b0;
      rst_n      = 1'b1;
      chk("arst_instr", instr, 32'h0000_0013);
      chk("arst_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("refetch_req", 32'(imem_req), 32'd1);
      chk("refetch_addr", imem_addr, 32'h0);
      chk("refetch_nop", instr, 32'h0000_0013);
      cur_pc = 32'h0;

      for (int n = 0; n < 40; n++) begin
         logic        src;
         logic [31:0] imm;
         logic [31:0] nxt;
         src = 1'($urandom);
         imm = $urandom & 32'hFFFF_FFFC;
         nxt = src ? cur_pc + imm : cur_pc + 32'd4;
         do_fetch($urandom_range(0, 3), $urandom_range(0, 3), src, imm, nxt);
      end

      // Misaligned branch target from pc=0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0013;
      tick();
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      PCSrc       = 1'b1;
      ImmExt      = 32'h6;
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("trap_mis", 32'(misaligned), 32'd1);
      chk("trap_pc", pc, 32'h6);
      chk("trap_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'b1;
         tick();
         chk("trap_req", 32'(imem_req), 32'd0);
      end
      imem_ack = 1'b0;
`else
      chk("mis_tied", 32'(misaligned), 32'd0);
      chk("align_req", 32'(imem_req), 32'd1);
      chk("align_addr", imem_addr, 32'h4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
